// File: rtl/if_fetch_unit_if.sv
// Instruction-bus bundle: single-outstanding request/ack handshake between the
// fetch unit (master) and the instruction memory (slave).
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one outstanding ibus request at a
// time and presents a single registered word to the IF/ID register.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_ctrl,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  if_fetch_unit_if.master   ibus,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst,
  output logic              stallreq_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              pend_br, pend_br_n;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_n;
  logic [ADDR_W-1:0] addr_p0, addr_n;
  logic [ADDR_W-1:0] word_pc_p1;
  logic [DATA_W-1:0] word_inst_p1;
  logic              vld_p1;
  logic              br_ev;
  logic              consume;
  logic              capture;
  logic              unused_stall;

  assign unused_stall = ^{stall_ctrl[5:3], stall_ctrl[0]};

  // A taken branch only counts once it actually leaves ID.
  assign br_ev   = branch_flag & ~stall_ctrl[2];
  assign consume = (state == HOLD) & ~stall_ctrl[1];

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_br_n  = pend_br;
    pend_tgt_n = pend_tgt;
    addr_n     = addr_p0;
    capture    = 1'b0;

    if (flush) begin
      pc_n      = new_pc;
      pend_br_n = 1'b0;
      unique case (state)
        // An in-flight request cannot be withdrawn; wait out its ack.
        REQ:     state_n = ibus.ack ? IDLE : DRAIN;
        DRAIN:   state_n = ibus.ack ? IDLE : DRAIN;
        default: state_n = IDLE;
      endcase
    end else begin
      if (br_ev) begin
        pend_br_n  = 1'b1;
        pend_tgt_n = branch_target;
      end
      unique case (state)
        IDLE: begin
          state_n = REQ;
          addr_n  = pc;
        end
        REQ: begin
          if (ibus.ack) begin
            state_n = HOLD;
            capture = 1'b1;
          end
        end
        HOLD: begin
          if (consume) begin
            state_n = IDLE;
            // The word leaving now is the delay slot of an earlier branch.
            if (pend_br) begin
              pc_n = pend_tgt;
              if (!br_ev) pend_br_n = 1'b0;
            end else if (br_ev) begin
              pc_n      = branch_target;
              pend_br_n = 1'b0;
            end else begin
              pc_n = pc + ADDR_W'(4);
            end
          end
        end
        DRAIN: begin
          if (ibus.ack) begin
            state_n = REQ;
            addr_n  = pc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_br <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_br <= pend_br_n;
    end
  end

  // p0: request address and branch target
  always_ff @(posedge clk) begin
    addr_p0  <= addr_n;
    pend_tgt <= pend_tgt_n;
  end

  // p1: presented word, captured on ack
  always_ff @(posedge clk) begin
    if (capture) begin
      word_pc_p1   <= ibus.addr;
      word_inst_p1 <= ibus.rdata;
    end
  end

  assign vld_p1      = (state == HOLD);
  assign ibus.req    = (state == REQ) || (state == DRAIN);
  assign ibus.addr   = ibus.req ? addr_p0 : '0;
  assign if_pc       = vld_p1 ? word_pc_p1 : '0;
  assign if_inst     = vld_p1 ? word_inst_p1 : '0;
  assign stallreq_if = ~vld_p1;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a wait-configurable instruction slave
// that returns 32'h2000_0000 + address.
module tb_if_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [5:0]    stall_ctrl;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic          branch_flag;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  logic          stallreq_if;

  int n_cmp;
  int n_err;
  int wait_cfg;
  int wcnt;

  if_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) ibus ();

  if_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_ctrl    (stall_ctrl),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .ibus          (ibus),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stallreq_if   (stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ibus.ack   = ibus.req && (wcnt >= wait_cfg);
  assign ibus.rdata = 32'h2000_0000 + ibus.addr;

  always @(posedge clk) begin
    if (!ibus.req || ibus.ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (ibus.req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0h want 0", ibus.req); end
    n_cmp++; if (ibus.addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 00000000", ibus.addr); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_if_pc got %h want 00000000", if_pc); end
    n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL rst_if_inst got %h want 00000000", if_inst); end
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL rst_stallreq got %0h want 1", stallreq_if); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h0) begin n_err++; $display("FAIL zw_first_req got req=%0h addr=%h want req=1 addr=00000000", ibus.req, ibus.addr); end
    step();
    n_cmp++; if (if_pc !== 32'h0 || if_inst !== 32'h2000_0000) begin n_err++; $display("FAIL zw_word0 got %h/%h want 00000000/20000000", if_pc, if_inst); end
    n_cmp++; if (stallreq_if !== 1'b0 || ibus.req !== 1'b0) begin n_err++; $display("FAIL zw_hold0 got stallreq=%0h req=%0h want 0/0", stallreq_if, ibus.req); end
    step();
    n_cmp++; if (stallreq_if !== 1'b1 || ibus.req !== 1'b0) begin n_err++; $display("FAIL zw_idle got stallreq=%0h req=%0h want 1/0", stallreq_if, ibus.req); end
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h4) begin n_err++; $display("FAIL zw_req4 got req=%0h addr=%h want 1/00000004", ibus.req, ibus.addr); end
    step();
    n_cmp++; if (if_pc !== 32'h4 || if_inst !== 32'h2000_0004) begin n_err++; $display("FAIL zw_word4 got %h/%h want 00000004/20000004", if_pc, if_inst); end
    step();
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h8) begin n_err++; $display("FAIL zw_req8 got req=%0h addr=%h want 1/00000008", ibus.req, ibus.addr); end
    step();
    n_cmp++; if (if_pc !== 32'h8 || if_inst !== 32'h2000_0008 || stallreq_if !== 1'b0) begin n_err++; $display("FAIL zw_word8 got %h/%h/%0h want 00000008/20000008/0", if_pc, if_inst, stallreq_if); end
  endtask

  task automatic test_hold();
    stall_ctrl = 6'b000011;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (if_pc !== 32'h8 || ibus.req !== 1'b0 || stallreq_if !== 1'b0) begin n_err++; $display("FAIL hold_%0d got pc=%h req=%0h stallreq=%0h want 00000008/0/0", i, if_pc, ibus.req, stallreq_if); end
    end
    stall_ctrl = 6'b000000;
    step();
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'hC) begin n_err++; $display("FAIL hold_release got req=%0h addr=%h want 1/0000000c", ibus.req, ibus.addr); end
    step();
    n_cmp++; if (if_pc !== 32'hC || if_inst !== 32'h2000_000C) begin n_err++; $display("FAIL hold_wordC got %h/%h want 0000000c/2000000c", if_pc, if_inst); end
  endtask

  task automatic test_wait_states();
    wait_cfg = 3;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h10 || stallreq_if !== 1'b1 || ibus.ack !== 1'b0) begin n_err++; $display("FAIL wait_%0d got req=%0h addr=%h stallreq=%0h ack=%0h want 1/00000010/1/0", i, ibus.req, ibus.addr, stallreq_if, ibus.ack); end
      step();
    end
    n_cmp++; if (ibus.ack !== 1'b1 || ibus.addr !== 32'h10 || stallreq_if !== 1'b1) begin n_err++; $display("FAIL wait_ack got ack=%0h addr=%h stallreq=%0h want 1/00000010/1", ibus.ack, ibus.addr, stallreq_if); end
    step();
    n_cmp++; if (if_pc !== 32'h10 || if_inst !== 32'h2000_0010 || stallreq_if !== 1'b0) begin n_err++; $display("FAIL wait_word got %h/%h/%0h want 00000010/20000010/0", if_pc, if_inst, stallreq_if); end
    wait_cfg = 0;
  endtask

  task automatic test_branch();
    step();
    branch_flag   = 1'b1;
    branch_target = 32'h100;
    step();
    branch_flag = 1'b0;
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h14) begin n_err++; $display("FAIL br_slot_req got req=%0h addr=%h want 1/00000014", ibus.req, ibus.addr); end
    step();
    n_cmp++; if (if_pc !== 32'h14 || if_inst !== 32'h2000_0014) begin n_err++; $display("FAIL br_slot_word got %h/%h want 00000014/20000014", if_pc, if_inst); end
    step();
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h100) begin n_err++; $display("FAIL br_target got req=%0h addr=%h want 1/00000100", ibus.req, ibus.addr); end
    step();
    branch_flag   = 1'b1;
    branch_target = 32'h200;
    stall_ctrl    = 6'b000100;
    step();
    branch_flag = 1'b0;
    stall_ctrl  = 6'b000000;
    step();
    n_cmp++; if (ibus.addr !== 32'h104) begin n_err++; $display("FAIL br_ignored got addr=%h want 00000104", ibus.addr); end
    step();
    branch_flag   = 1'b1;
    branch_target = 32'h100;
    step();
    branch_flag = 1'b0;
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h100) begin n_err++; $display("FAIL br_same_edge got req=%0h addr=%h want 1/00000100", ibus.req, ibus.addr); end
    step();
    step();
    step();
    n_cmp++; if (ibus.addr !== 32'h104) begin n_err++; $display("FAIL br_no_pending got addr=%h want 00000104", ibus.addr); end
    step();
  endtask

  task automatic test_flush_drain();
    wait_cfg = 2;
    step();
    step();
    flush  = 1'b1;
    new_pc = 32'h180;
    step();
    flush = 1'b0;
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h108 || stallreq_if !== 1'b1) begin n_err++; $display("FAIL drain_hold got req=%0h addr=%h stallreq=%0h want 1/00000108/1", ibus.req, ibus.addr, stallreq_if); end
    step();
    n_cmp++; if (ibus.ack !== 1'b1 || ibus.addr !== 32'h108 || if_inst !== 32'h0) begin n_err++; $display("FAIL drain_ack got ack=%0h addr=%h inst=%h want 1/00000108/00000000", ibus.ack, ibus.addr, if_inst); end
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h180 || if_inst !== 32'h0) begin n_err++; $display("FAIL drain_redirect got req=%0h addr=%h inst=%h want 1/00000180/00000000", ibus.req, ibus.addr, if_inst); end
    step();
    step();
    step();
    n_cmp++; if (if_pc !== 32'h180 || if_inst !== 32'h2000_0180) begin n_err++; $display("FAIL drain_word got %h/%h want 00000180/20000180", if_pc, if_inst); end
    wait_cfg = 0;
  endtask

  task automatic test_flush_ack();
    step();
    step();
    flush  = 1'b1;
    new_pc = 32'h40;
    step();
    flush = 1'b0;
    n_cmp++; if (ibus.req !== 1'b0 || stallreq_if !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0) begin n_err++; $display("FAIL fack_discard got req=%0h stallreq=%0h pc=%h inst=%h want 0/1/0/0", ibus.req, stallreq_if, if_pc, if_inst); end
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h40) begin n_err++; $display("FAIL fack_redirect got req=%0h addr=%h want 1/00000040", ibus.req, ibus.addr); end
    step();
    n_cmp++; if (if_pc !== 32'h40 || if_inst !== 32'h2000_0040) begin n_err++; $display("FAIL fack_word got %h/%h want 00000040/20000040", if_pc, if_inst); end
  endtask

  task automatic test_rst_mid();
    wait_cfg = 3;
    step();
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h44) begin n_err++; $display("FAIL rstm_req got req=%0h addr=%h want 1/00000044", ibus.req, ibus.addr); end
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (ibus.req !== 1'b0 || ibus.addr !== 32'h0 || stallreq_if !== 1'b1) begin n_err++; $display("FAIL rstm_abandon got req=%0h addr=%h stallreq=%0h want 0/0/1", ibus.req, ibus.addr, stallreq_if); end
    rst      = 1'b0;
    wait_cfg = 0;
    step();
    n_cmp++; if (ibus.req !== 1'b1 || ibus.addr !== 32'h0) begin n_err++; $display("FAIL rstm_refetch got req=%0h addr=%h want 1/00000000", ibus.req, ibus.addr); end
    step();
    n_cmp++; if (if_pc !== 32'h0 || if_inst !== 32'h2000_0000) begin n_err++; $display("FAIL rstm_word got %h/%h want 00000000/20000000", if_pc, if_inst); end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    wait_cfg      = 0;
    wcnt          = 0;
    rst           = 1'b1;
    stall_ctrl    = 6'b000000;
    flush         = 1'b0;
    new_pc        = 32'h0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    step();
    step();
    test_reset();
    test_zero_wait();
    test_hold();
    test_wait_states();
    test_branch();
    test_flush_drain();
    test_flush_ack();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
